mips_multicycle_controller: RTL and testbench
=============================================

# mips_multicycle_controller

Main control FSM for the multicycle MIPS core. It sequences the shared ALU, register file, instruction register and a single unified memory over 3–5 cycles per instruction. Each cycle it issues ALUOp to the downstream ALU decoder and drives the datapath mux selects and write enables. It waits on a memory-ready handshake in every memory-access state.

## Interface
Parameters:
- none; opcode values and state encodings come from the shared package.

Ports:
- `clk` in 1: single clock. All state updates occur on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `Op` in 6: opcode field of the instruction register (bits 31:26).
- `Zero` in 1: ALU zero flag.
- `MemReady` in 1: memory has completed the current read or write this cycle.
- `IorD` out 1: memory address select (0 = PC, 1 = ALUOut).
- `MemWrite` out 1: memory write strobe.
- `IRWrite` out 1: instruction register load.
- `RegDst` out 1: register-file write address select (0 = rt, 1 = rd).
- `MemtoReg` out 1: register-file write data select (0 = ALUOut, 1 = Data).
- `RegWrite` out 1: register-file write enable.
- `ALUSrcA` out 1: ALU operand A select (0 = PC, 1 = A).
- `ALUSrcB` out 2: ALU operand B select (00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2).
- `ALUOp` out 2: to ALU decoder (00 = add, 01 = subtract, 10 = use Funct).
- `PCSrc` out 2: PC source (00 = ALUResult, 01 = ALUOut, 10 = jump target).
- `PCEn` out 1: PC load enable, equal to PCWrite | (Branch & Zero).
- `Illegal` out 1: one-cycle pulse in DECODE when Op is unsupported.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Default output values in every state are 0, except where a state lists otherwise.
- States and their active outputs:
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=PCWrite=MemReady. Stays in FETCH while MemReady=0. Goes to DECODE when MemReady=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
    - lw/sw → MEMADR
    - R-type → EXECUTE
    - beq → BRANCH
    - addi → ADDIEXEC
    - j → JUMP
    - any other opcode → FETCH, with Illegal=1.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: IorD=1. Stays until MemReady=1, then goes to MEMWB.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next is FETCH.
  - MEMWRITE: IorD=1, MemWrite=1, held for every cycle spent in this state. Goes to FETCH when MemReady=1.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next is ALUWB.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next is FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. Next is FETCH.
  - ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is ADDIWB.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next is FETCH.
  - JUMP: PCSrc=10, PCWrite=1. Next is FETCH.
- Output classes:
  - IRWrite, PCWrite and PCEn are Mealy outputs (they depend on MemReady or Zero).
  - All other outputs are Moore outputs of the state.
- Op is sampled only in DECODE and MEMADR.

## Timing
- Reset: state becomes FETCH immediately (asynchronous). While in reset, outputs take the FETCH values with IRWrite=PCWrite=PCEn=0 and Illegal=0; all other write enables are 0.
- Reset release: the first rising edge after rst goes high may advance the FSM.
- Cycle counts with MemReady tied to 1:
  - j, beq: 3
  - R-type, sw, addi: 4
  - lw: 5
- Each cycle MemReady is low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- No write enable may be asserted during a wait cycle, except MemWrite in MEMWRITE.
- beq: PCEn=1 in BRANCH only when Zero=1 in that same cycle.
- Illegal opcode: one DECODE cycle with Illegal=1, then FETCH. No register-file, memory or PC write occurs.
- Reset asserted mid-instruction: the instruction is abandoned. No further RegWrite, MemWrite or PCEn occurs until a new FETCH completes.

## Structure
- Package `mips_mc_pkg` holds:
  - the opcode localparams
  - the state enum (4-bit encoding; FETCH = 0)
  - the ALUOp constants (ADD = 00, SUB = 01, FUNCT = 10)
  - the ALUSrcB and PCSrc select constants
- One sub-module, `mc_output_decoder`: purely combinational; maps state, MemReady and Zero to all control outputs.
- Top module holds the state register and the next-state logic.

## Test plan
- Reset held low, MemReady=1 → outputs match FETCH values with IRWrite=PCEn=0. After rst goes high, the first edge moves to DECODE with IRWrite=PCEn=1 pulsed.
- lw (Op=100011) with MemReady=0 for 2 cycles in MEMREAD → 7 cycles total. RegWrite=1 with MemtoReg=1 and RegDst=0 for exactly one cycle, in MEMWB.
- sw (Op=101011), MemReady=1 → 4 cycles. MemWrite=1 with IorD=1 in cycle 4 only. No RegWrite at any point.
- beq (Op=000100) with Zero=1 → PCEn=1 with PCSrc=01 in cycle 3. Repeat with Zero=0 → PCEn=0 in cycle 3.
- R-type then addi back-to-back → ALUOp=10 in EXECUTE and 00 in ADDIEXEC. RegDst=1 then 0 at the respective writebacks.
- Op=111111 → Illegal=1 for one cycle and return to FETCH. Separately, rst asserted during MEMWRITE → MemWrite drops at once and the FSM is in FETCH.

Source files
------------

// File: rtl/mips_multicycle_controller_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, FSM state
// encoding and the datapath select constants.
package mips_mc_pkg;

  // Supported opcodes (instruction bits 31:26)
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Controller states; FETCH must stay at zero so reset lands there
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  // ALU decoder operation
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True for every opcode the controller knows how to sequence
  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_multicycle_controller_if.sv
// Controller <-> datapath bundle. The master side is the controller: it
// samples the opcode, ALU flag and memory ready, and drives all selects and
// write enables. MemReady is a level handshake: a memory-access state holds
// its outputs unchanged every cycle MemReady is low and leaves on the first
// cycle it is high. dbg_state mirrors the FSM state register for observation.
interface mips_multicycle_controller_if;
  logic [5:0] Op;
  logic       Zero;
  logic       MemReady;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       Illegal;
  logic [3:0] dbg_state;

  modport master (
    input  Op, Zero, MemReady,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, Illegal, dbg_state
  );

  modport slave (
    output Op, Zero, MemReady,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, Illegal, dbg_state
  );
endinterface

// File: rtl/mips_multicycle_controller_decoder.sv
// Combinational output decode: state plus MemReady/Zero/Op to every control
// output. Moore outputs depend on state only; IRWrite/PCEn depend on MemReady
// or Zero and are forced low while reset is asserted.
module mc_output_decoder
  import mips_mc_pkg::*;
(
  input  state_e     state_i,
  input  logic       rst_n_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  input  logic [5:0] op_i,
  output logic       iord_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_src_o,
  output logic       pc_en_o,
  output logic       illegal_o
);

  logic ir_write_c;
  logic pc_write_c;
  logic branch_c;

  // Per-state output table; everything not listed for a state stays 0
  always_comb begin
    iord_o       = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_c   = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRCB_B;
    alu_op_o     = ALUOP_ADD;
    pc_src_o     = PCSRC_ALU;
    pc_write_c   = 1'b0;
    branch_c     = 1'b0;
    illegal_o    = 1'b0;
    case (state_i)
      S_FETCH: begin
        alu_src_b_o = SRCB_FOUR;
        ir_write_c  = mem_ready_i;
        pc_write_c  = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_b_o = SRCB_IMM_SH2;
        illegal_o   = !op_supported(op_i);
      end
      S_MEMADR, S_ADDIEXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      S_MEMREAD: iord_o = 1'b1;
      S_MEMWB: begin
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
      end
      S_MEMWRITE: begin
        iord_o      = 1'b1;
        mem_write_o = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_dst_o   = 1'b1;
        reg_write_o = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALUOP_SUB;
        pc_src_o    = PCSRC_ALUOUT;
        branch_c    = 1'b1;
      end
      S_ADDIWB: reg_write_o = 1'b1;
      S_JUMP: begin
        pc_src_o   = PCSRC_JUMP;
        pc_write_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign ir_write_o = ir_write_c & rst_n_i;
  assign pc_en_o    = (pc_write_c | (branch_c & zero_i)) & rst_n_i;

endmodule

// File: rtl/mips_multicycle_controller.sv
// Main control FSM of the multicycle MIPS core: state register and next-state
// sequencing; outputs come from mc_output_decoder.
module mips_multicycle_controller
  import mips_mc_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  mips_multicycle_controller_if.master   bus
);

  state_e state_q;
  state_e state_d;

  // Next-state sequencing; Op is only looked at in DECODE and MEMADR
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (bus.MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (bus.Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.MemReady) state_d = S_MEMWB;
      S_MEMWRITE: if (bus.MemReady) state_d = S_FETCH;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  assign bus.dbg_state = state_q;

  mc_output_decoder u_dec (
    .state_i      (state_q),
    .rst_n_i      (rst),
    .mem_ready_i  (bus.MemReady),
    .zero_i       (bus.Zero),
    .op_i         (bus.Op),
    .iord_o       (bus.IorD),
    .mem_write_o  (bus.MemWrite),
    .ir_write_o   (bus.IRWrite),
    .reg_dst_o    (bus.RegDst),
    .mem_to_reg_o (bus.MemtoReg),
    .reg_write_o  (bus.RegWrite),
    .alu_src_a_o  (bus.ALUSrcA),
    .alu_src_b_o  (bus.ALUSrcB),
    .alu_op_o     (bus.ALUOp),
    .pc_src_o     (bus.PCSrc),
    .pc_en_o      (bus.PCEn),
    .illegal_o    (bus.Illegal)
  );

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for the multicycle MIPS controller: each instruction is expanded into
// its per-cycle step list from the opcode and wait counts, and every cycle the
// full control word is compared against the expected word for that step.
module tb_mips_multicycle_controller;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       illegal;
  } ctl_t;

  typedef enum int {
    K_FETCH, K_DECODE, K_MEMADR, K_MEMREAD, K_MEMWB, K_MEMWRITE,
    K_EXECUTE, K_ALUWB, K_BRANCH, K_ADDIEXEC, K_ADDIWB, K_JUMP
  } kind_e;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [14:0] exp_q[$];
  logic        rdy_q[$];
  logic        zero_q[$];
  logic [5:0]  op_q[$];

  mips_multicycle_controller_if bus ();

  mips_multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t observed();
    ctl_t c;
    c.iord     = bus.IorD;
    c.memwrite = bus.MemWrite;
    c.irwrite  = bus.IRWrite;
    c.regdst   = bus.RegDst;
    c.memtoreg = bus.MemtoReg;
    c.regwrite = bus.RegWrite;
    c.alusrca  = bus.ALUSrcA;
    c.alusrcb  = bus.ALUSrcB;
    c.aluop    = bus.ALUOp;
    c.pcsrc    = bus.PCSrc;
    c.pcen     = bus.PCEn;
    c.illegal  = bus.Illegal;
    return c;
  endfunction

  // Control word the datapath should see during one step of an instruction
  function automatic ctl_t expect_word(kind_e k, logic rdy, logic z, logic [5:0] op);
    ctl_t c;
    c = '0;
    case (k)
      K_FETCH:    begin c.alusrcb = 2'b01; c.irwrite = rdy; c.pcen = rdy; end
      K_DECODE:   begin
        c.alusrcb = 2'b11;
        c.illegal = !(op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
                      op == 6'b000100 || op == 6'b001000 || op == 6'b000010);
      end
      K_MEMADR:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      K_MEMREAD:  c.iord = 1'b1;
      K_MEMWB:    begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      K_MEMWRITE: begin c.iord = 1'b1; c.memwrite = 1'b1; end
      K_EXECUTE:  begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      K_ALUWB:    begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      K_BRANCH:   begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.pcen = z; end
      K_ADDIEXEC: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      K_ADDIWB:   c.regwrite = 1'b1;
      K_JUMP:     begin c.pcsrc = 2'b10; c.pcen = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic void push_step(kind_e k, logic rdy, logic z, logic [5:0] op);
    exp_q.push_back(expect_word(k, rdy, z, op));
    rdy_q.push_back(rdy);
    zero_q.push_back(z);
    op_q.push_back(op);
  endfunction

  // Expand one instruction into its cycle-by-cycle step list
  task automatic build(input logic [5:0] op, input int fw, input int mw, input logic z);
    for (int i = 0; i < fw; i++) push_step(K_FETCH, 1'b0, 1'($urandom_range(1)), 6'($urandom));
    push_step(K_FETCH, 1'b1, 1'($urandom_range(1)), 6'($urandom));
    push_step(K_DECODE, 1'($urandom_range(1)), 1'($urandom_range(1)), op);
    case (op)
      6'b100011: begin
        push_step(K_MEMADR, 1'($urandom_range(1)), 1'($urandom_range(1)), op);
        for (int i = 0; i < mw; i++) push_step(K_MEMREAD, 1'b0, 1'($urandom_range(1)), op);
        push_step(K_MEMREAD, 1'b1, 1'($urandom_range(1)), op);
        push_step(K_MEMWB, 1'($urandom_range(1)), 1'($urandom_range(1)), op);
      end
      6'b101011: begin
        push_step(K_MEMADR, 1'($urandom_range(1)), 1'($urandom_range(1)), op);
        for (int i = 0; i < mw; i++) push_step(K_MEMWRITE, 1'b0, 1'($urandom_range(1)), op);
        push_step(K_MEMWRITE, 1'b1, 1'($urandom_range(1)), op);
      end
      6'b000000: begin
        push_step(K_EXECUTE, 1'($urandom_range(1)), 1'($urandom_range(1)), op);
        push_step(K_ALUWB, 1'($urandom_range(1)), 1'($urandom_range(1)), op);
      end
      6'b000100: push_step(K_BRANCH, 1'($urandom_range(1)), z, op);
      6'b001000: begin
        push_step(K_ADDIEXEC, 1'($urandom_range(1)), 1'($urandom_range(1)), op);
        push_step(K_ADDIWB, 1'($urandom_range(1)), 1'($urandom_range(1)), op);
      end
      6'b000010: push_step(K_JUMP, 1'($urandom_range(1)), 1'($urandom_range(1)), op);
      default: ;
    endcase
  endtask

  // Drive the first max_steps queued steps, checking each cycle; a full run
  // additionally checks the FSM is back in FETCH afterwards
  task automatic run_instr(input string name, input logic [5:0] op, input int fw,
                           input int mw, input logic z, input int max_steps,
                           output int cycles);
    ctl_t exp_w;
    ctl_t act_w;
    int   n;
    build(op, fw, mw, z);
    n = exp_q.size();
    if (max_steps < n) n = max_steps;
    cycles = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.MemReady = rdy_q.pop_front();
      bus.Zero     = zero_q.pop_front();
      bus.Op       = op_q.pop_front();
      exp_w        = exp_q.pop_front();
      #1;
      act_w = observed();
      checks++;
      if (act_w !== exp_w) begin
        errors++;
        $display("FAIL %s step %0d: got %h expected %h", name, i, act_w, exp_w);
      end
      cycles++;
    end
    if (exp_q.size() == 0) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.dbg_state !== 4'd0) begin
        errors++;
        $display("FAIL %s end_in_fetch: state %0d expected 0", name, bus.dbg_state);
      end
    end
    exp_q.delete();
    rdy_q.delete();
    zero_q.delete();
    op_q.delete();
  endtask

  task automatic check_cycles(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycles: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    ctl_t w;
    rst = 1'b0;
    bus.MemReady = 1'b1;
    bus.Zero = 1'b1;
    bus.Op = 6'b000010;
    @(negedge clk);
    @(negedge clk);
    #1;
    w = observed();
    checks++;
    if (w !== expect_word(K_FETCH, 1'b0, 1'b0, 6'd0)) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", w, expect_word(K_FETCH, 1'b0, 1'b0, 6'd0));
    end
    checks++;
    if (bus.dbg_state !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", bus.dbg_state);
    end
    rst = 1'b1;
    #1;
    w = observed();
    checks++;
    if (w !== expect_word(K_FETCH, 1'b1, 1'b0, 6'd0)) begin
      errors++;
      $display("FAIL release_fetch: got %h expected %h", w, expect_word(K_FETCH, 1'b1, 1'b0, 6'd0));
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.dbg_state !== 4'd1 || bus.IRWrite !== 1'b0) begin
      errors++;
      $display("FAIL release_decode: state %0d irwrite %b expected 1 0", bus.dbg_state, bus.IRWrite);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.dbg_state !== 4'd0 || bus.Illegal !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: state %0d illegal %b expected 0 0", bus.dbg_state, bus.Illegal);
    end
    @(negedge clk);
    bus.MemReady = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_lw();
    int c;
    run_instr("lw_wait2", 6'b100011, 0, 2, 1'b0, 99, c);
    check_cycles("lw_wait2", c, 7);
    run_instr("lw_nowait", 6'b100011, 0, 0, 1'b0, 99, c);
    check_cycles("lw_nowait", c, 5);
  endtask

  task automatic test_sw();
    int c;
    run_instr("sw", 6'b101011, 0, 0, 1'b0, 99, c);
    check_cycles("sw", c, 4);
  endtask

  task automatic test_beq();
    int c;
    run_instr("beq_taken", 6'b000100, 0, 0, 1'b1, 99, c);
    check_cycles("beq_taken", c, 3);
    run_instr("beq_not_taken", 6'b000100, 0, 0, 1'b0, 99, c);
    check_cycles("beq_not_taken", c, 3);
  endtask

  task automatic test_back_to_back();
    int c;
    run_instr("rtype", 6'b000000, 0, 0, 1'b0, 99, c);
    check_cycles("rtype", c, 4);
    run_instr("addi", 6'b001000, 0, 0, 1'b0, 99, c);
    check_cycles("addi", c, 4);
    run_instr("jump", 6'b000010, 1, 0, 1'b0, 99, c);
    check_cycles("jump_fetchwait", c, 4);
  endtask

  task automatic test_illegal();
    int c;
    run_instr("illegal", 6'b111111, 0, 0, 1'b0, 99, c);
    check_cycles("illegal", c, 2);
  endtask

  task automatic test_reset_mid();
    int c;
    // stop inside MEMWRITE while memory is still busy
    run_instr("sw_abort", 6'b101011, 0, 3, 1'b0, 4, c);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.MemWrite !== 1'b0 || bus.IorD !== 1'b0 || bus.dbg_state !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid: memwrite %b iord %b state %0d expected 0 0 0",
               bus.MemWrite, bus.IorD, bus.dbg_state);
    end
    @(negedge clk);
    bus.MemReady = 1'b0;
    rst = 1'b1;
    run_instr("after_abort", 6'b000000, 0, 0, 1'b0, 99, c);
  endtask

  task automatic test_random();
    logic [5:0] ops [7];
    int c;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b000000};
    for (int i = 0; i < 60; i++) begin
      logic [5:0] op;
      op = ops[$urandom_range(5)];
      if ($urandom_range(7) == 0) op = 6'($urandom);
      run_instr("random", op, $urandom_range(2), $urandom_range(3),
                1'($urandom_range(1)), 99, c);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_lw();
    test_sw();
    test_beq();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
